// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button arbiter (master) and its consumer (slave).
// The consumer accepts the offered event when evt_valid and evt_ready are both
// high at a rising clock edge.
interface button_event_arbiter_if #(
   parameter int IDW = 2
);
   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic           evt_ready;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: latches rising edges of N_BTN button levels as pending
// requests and serializes them round-robin onto one valid/ready event channel.
// A press on a button that is already pending sets its sticky overrun bit.
// Optional feature macro: DEBOUNCE_EN (per-button stable-sample debouncer in
// front of the edge detector; absent by default).
module button_event_arbiter #(
   parameter int N_BTN           = 4,
   parameter int IDW             = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N_BTN-1:0]           btn,
   button_event_arbiter_if.master     evt,
   output logic [N_BTN-1:0]           pending,
   output logic [N_BTN-1:0]           overrun,
   input  logic                       overrun_clr
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   logic [0:0]       r_state;
   logic             r_valid;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   r_ptr;
   logic [N_BTN-1:0] r_prev;
   logic [N_BTN-1:0] r_pending;
   logic [N_BTN-1:0] r_overrun;

   logic [N_BTN-1:0] w_lvl;
   logic [N_BTN-1:0] w_rise;
   logic [N_BTN-1:0] w_grant;
   logic [IDW-1:0]   w_pick;

`ifdef DEBOUNCE_EN
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [N_BTN-1:0][DBW-1:0] r_db_cnt;
   logic [N_BTN-1:0]          r_deb;

   // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES samples
   always_ff @(posedge clock) begin
      if (reset) begin
         r_db_cnt <= '0;
         r_deb    <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (btn[i] == r_deb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb[i]    <= btn[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_lvl = r_deb;
`else
   assign w_lvl = btn;
`endif

   assign w_rise = w_lvl & ~r_prev;

   // Round-robin pick: first set request scanning ptr, ptr+1, ... with wrap at N_BTN
   function automatic logic [IDW-1:0] f_rr_pick(input logic [N_BTN-1:0] req,
                                               input logic [IDW-1:0]   ptr);
      logic [IDW-1:0] sel;
      logic           found;
      int             idx;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < N_BTN; k++) begin
         idx = (int'(ptr) + k) % N_BTN;
         if (!found && req[idx]) begin
            sel   = IDW'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // Per-button grant decode and round-robin selection from the registered pending set
   always_comb begin
      w_grant = '0;
      for (int i = 0; i < N_BTN; i++) begin
         w_grant[i] = r_valid & evt.evt_ready & (r_id == IDW'(i));
      end
      w_pick = f_rr_pick(r_pending, r_ptr);
   end

   // Edge history, pending set/clear (a press coinciding with its grant is kept) and sticky overrun
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prev    <= '0;
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         r_prev    <= w_lvl;
         r_pending <= (r_pending & ~w_grant) | w_rise;
         if (overrun_clr) begin
            r_overrun <= '0;
         end else begin
            r_overrun <= r_overrun | (w_rise & r_pending & ~w_grant);
         end
      end
   end

   // Offer FSM: select in IDLE, hold id/valid in OFFER until accepted, then advance ptr past the winner
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|r_pending) begin
                  r_id    <= w_pick;
                  r_valid <= 1'b1;
                  r_state <= ST_OFFER;
               end else begin
                  r_valid <= 1'b0;
               end
            end
            ST_OFFER: begin
               if (evt.evt_ready) begin
                  r_valid <= 1'b0;
                  r_ptr   <= (r_id == IDW'(N_BTN - 1)) ? '0 : r_id + 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign evt.evt_valid = r_valid;
   assign evt.evt_id    = r_id;
   assign pending       = r_pending;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N_BTN=4). Inputs change and outputs
// are sampled 1 time unit after each rising edge. Build with DEBOUNCE_EN to
// run the debounce scenarios instead of the plain-path scenarios.
module tb_button_event_arbiter;

   logic       clock;
   logic       reset;
   logic [3:0] btn;
   logic [3:0] pending;
   logic [3:0] overrun;
   logic       overrun_clr;

   int n_chk;
   int n_fail;

   button_event_arbiter_if #(.IDW(2)) evt_if ();

   button_event_arbiter #(
      .N_BTN(4), .IDW(2), .DEBOUNCE_CYCLES(16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn         (btn),
      .evt         (evt_if),
      .pending     (pending),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_evt(input string tag, input logic v, input logic [1:0] id);
      chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(v));
      if (v) chk({tag, "_id"}, 32'(evt_if.evt_id), 32'(id));
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      reset = 1'b1;
      btn = 4'b0000;
      overrun_clr = 1'b0;
      evt_if.evt_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid",   32'(evt_if.evt_valid), 32'd0);
      chk("rst_id",      32'(evt_if.evt_id),    32'd0);
      chk("rst_pending", 32'(pending),          32'd0);
      chk("rst_overrun", 32'(overrun),          32'd0);
      reset = 1'b0;

`ifdef DEBOUNCE_EN
      // glitch of 5 cycles is filtered
      evt_if.evt_ready = 1'b1;
      btn = 4'b0010;
      for (int c = 0; c < 5; c++) tick();
      btn = 4'b0000;
      for (int c = 0; c < 20; c++) tick();
      chk("glitch_pending", 32'(pending), 32'd0);
      chk("glitch_valid",   32'(evt_if.evt_valid), 32'd0);
      // held high: valid appears at the 18th edge after the level change
      btn = 4'b0010;
      for (int c = 1; c <= 17; c++) begin
         tick();
         chk("db_wait_valid", 32'(evt_if.evt_valid), 32'd0);
      end
      chk("db_pending", 32'(pending), 32'b0010);
      tick();
      chk_evt("db_evt", 1'b1, 2'd1);
      tick();
      chk_evt("db_after", 1'b0, 2'd0);
      chk("db_pending_clr", 32'(pending), 32'd0);
      tick();
      tick();
      chk_evt("db_single", 1'b0, 2'd0);
`else
      // single press on btn[2]
      evt_if.evt_ready = 1'b1;
      btn = 4'b0100;
      tick();
      chk("t1_pending", 32'(pending), 32'b0100);
      chk_evt("t1_e1", 1'b0, 2'd0);
      tick();
      chk_evt("t1_e2", 1'b1, 2'd2);
      chk("t1_pend_hold", 32'(pending), 32'b0100);
      tick();
      btn = 4'b0000;
      chk_evt("t1_e3", 1'b0, 2'd0);
      chk("t1_pend_clr", 32'(pending), 32'd0);
      chk("t1_overrun",  32'(overrun), 32'd0);

      // reset to bring ptr back to 0, then simultaneous presses 1011
      reset = 1'b1;
      tick();
      reset = 1'b0;
      btn = 4'b1011;
      tick();
      chk("t2_pending", 32'(pending), 32'b1011);
      tick();
      chk_evt("t2_g0", 1'b1, 2'd0);
      tick();
      chk_evt("t2_gap0", 1'b0, 2'd0);
      chk("t2_pend1", 32'(pending), 32'b1010);
      tick();
      chk_evt("t2_g1", 1'b1, 2'd1);
      tick();
      chk_evt("t2_gap1", 1'b0, 2'd0);
      chk("t2_pend2", 32'(pending), 32'b1000);
      tick();
      chk_evt("t2_g3", 1'b1, 2'd3);
      tick();
      chk_evt("t2_gap3", 1'b0, 2'd0);
      chk("t2_pend3", 32'(pending), 32'd0);
      btn = 4'b0000;
      tick();

      // stalled offer of id 1 plus re-press -> overrun, one delivery
      evt_if.evt_ready = 1'b0;
      btn = 4'b0010;
      tick();
      tick();
      chk_evt("t3_offer", 1'b1, 2'd1);
      btn = 4'b0000;
      tick();
      chk_evt("t3_hold1", 1'b1, 2'd1);
      btn = 4'b0010;
      tick();
      chk_evt("t3_hold2", 1'b1, 2'd1);
      chk("t3_overrun", 32'(overrun), 32'b0010);
      evt_if.evt_ready = 1'b1;
      tick();
      chk_evt("t3_grant", 1'b0, 2'd0);
      chk("t3_pending", 32'(pending), 32'd0);
      tick();
      tick();
      chk_evt("t3_no_second", 1'b0, 2'd0);
      chk("t3_ovr_sticky", 32'(overrun), 32'b0010);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("t3_ovr_clr", 32'(overrun), 32'd0);
      btn = 4'b0000;
      tick();

      // re-press of btn[3] on its own grant edge keeps it pending
      evt_if.evt_ready = 1'b0;
      btn = 4'b1000;
      tick();
      tick();
      chk_evt("t4_offer", 1'b1, 2'd3);
      btn = 4'b0000;
      tick();
      btn = 4'b1000;
      evt_if.evt_ready = 1'b1;
      tick();
      chk_evt("t4_grant", 1'b0, 2'd0);
      chk("t4_pending", 32'(pending), 32'b1000);
      chk("t4_overrun", 32'(overrun), 32'd0);
      tick();
      chk_evt("t4_second", 1'b1, 2'd3);
      tick();
      chk_evt("t4_done", 1'b0, 2'd0);
      chk("t4_pend_clr", 32'(pending), 32'd0);

      // reset while offering with pending 0110; btn[0] held through reset
      evt_if.evt_ready = 1'b0;
      btn = 4'b0110;
      tick();
      chk("t5_pending", 32'(pending), 32'b0110);
      tick();
      chk_evt("t5_offer", 1'b1, 2'd1);
      btn = 4'b0001;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      evt_if.evt_ready = 1'b1;
      chk_evt("t5_rst_valid", 1'b0, 2'd0);
      chk("t5_rst_pending", 32'(pending), 32'd0);
      tick();
      chk("t5_held_pending", 32'(pending), 32'b0001);
      tick();
      chk_evt("t5_evt0", 1'b1, 2'd0);
      tick();
      chk_evt("t5_after", 1'b0, 2'd0);
      tick();
      tick();
      chk_evt("t5_single", 1'b0, 2'd0);
      chk("t5_pend_end", 32'(pending), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
